// File: rtl/rv32v_lane_group_sequencer.sv
// Lane-group sequencer: splits one vector instruction into NUM_LANES-wide groups with per-lane enable/offset/address.
// Optional macro RV32V_SEQ_SKIP_EMPTY_EN: groups with no enabled lane are stepped over internally instead of presented.
module rv32v_lane_group_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int MAX_VL    = 32,
    parameter int VL_W      = 6,
    parameter int XLEN      = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        start,
    input  logic [VL_W-1:0]             vl,
    input  logic                        vm,
    input  logic [MAX_VL-1:0]           mask_v0,
    input  logic [XLEN-1:0]             base_addr,
    input  logic                        stride_en,
    input  logic [XLEN-1:0]             stride,
    input  logic [2:0]                  eew_bytes,
    input  logic                        flush,
    input  logic                        grp_ready,
    output logic                        busy,
    output logic                        grp_valid,
    output logic                        grp_last,
    output logic [NUM_LANES-1:0]        lane_en,
    output logic [NUM_LANES*VL_W-1:0]   lane_offset,
    output logic [NUM_LANES*XLEN-1:0]   lane_addr,
    output logic                        done
);

    localparam int LANE_SH = $clog2(NUM_LANES);
    localparam int VW1     = VL_W + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DONE = 2'd2} state_t;

    function automatic logic [XLEN-1:0] step_of(input logic sen, input logic [XLEN-1:0] st,
                                                 input logic [2:0] ew);
        return sen ? st : XLEN'(ew);
    endfunction

    state_t              state_r, state_s;
    logic [VL_W-1:0]     idx_r, idx_s, vl_r, vl_s;
    logic [XLEN-1:0]     base_r, base_s, stride_r, stride_s, step_n_s;
    logic                vm_r, vm_s, stride_en_r, stride_en_s;
    logic [MAX_VL-1:0]   mask_r, mask_s;
    logic [2:0]          eew_r, eew_s;

    logic                       busy_s, valid_s, last_s, done_s;
    logic [NUM_LANES-1:0]       en_s;
    logic [NUM_LANES*VL_W-1:0]  off_s;
    logic [NUM_LANES*XLEN-1:0]  addr_s;

`ifdef RV32V_SEQ_SKIP_EMPTY_EN
    logic empty_s;
    assign empty_s = (lane_en == '0);
`endif

    // State and captured-instruction registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            base_r      <= '0;
            vl_r        <= '0;
            vm_r        <= 1'b0;
            mask_r      <= '0;
            stride_en_r <= 1'b0;
            stride_r    <= '0;
            eew_r       <= 3'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            base_r      <= base_s;
            vl_r        <= vl_s;
            vm_r        <= vm_s;
            mask_r      <= mask_s;
            stride_en_r <= stride_en_s;
            stride_r    <= stride_s;
            eew_r       <= eew_s;
        end
    end

    // Next-state and group-advance logic; flush overrides everything.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        base_s      = base_r;
        vl_s        = vl_r;
        vm_s        = vm_r;
        mask_s      = mask_r;
        stride_en_s = stride_en_r;
        stride_s    = stride_r;
        eew_s       = eew_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!start) begin
                        state_s = ST_IDLE;
                    end else if (vl == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s     = ST_ISSUE;
                        idx_s       = '0;
                        base_s      = base_addr;
                        vl_s        = vl;
                        vm_s        = vm;
                        mask_s      = mask_v0;
                        stride_en_s = stride_en;
                        stride_s    = stride;
                        eew_s       = eew_bytes;
                    end
                end
                ST_ISSUE: begin
`ifdef RV32V_SEQ_SKIP_EMPTY_EN
                    if (empty_s || (grp_valid && grp_ready)) begin
`else
                    if (grp_valid && grp_ready) begin
`endif
                        if (grp_last) begin
                            state_s = ST_DONE;
                        end else begin
                            idx_s  = idx_r + VL_W'(NUM_LANES);
                            base_s = base_r + (step_of(stride_en_r, stride_r, eew_r) << LANE_SH);
                        end
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output values for the upcoming state; lanes past vl never look at the mask.
    always_comb begin
        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_DONE);
        valid_s  = 1'b0;
        last_s   = 1'b0;
        en_s     = '0;
        off_s    = '0;
        addr_s   = '0;
        step_n_s = step_of(stride_en_s, stride_s, eew_s);
        if (state_s == ST_ISSUE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                off_s[i*VL_W +: VL_W]  = idx_s + VL_W'(i);
                en_s[i] = (({1'b0, idx_s} + VW1'(i)) < {1'b0, vl_s}) &&
                          (vm_s || (((mask_s >> ({1'b0, idx_s} + VW1'(i))) & MAX_VL'(1)) != '0));
                addr_s[i*XLEN +: XLEN] = base_s + XLEN'(i) * step_n_s;
            end
            last_s = (({1'b0, idx_s} + VW1'(NUM_LANES)) >= {1'b0, vl_s});
`ifdef RV32V_SEQ_SKIP_EMPTY_EN
            valid_s = |en_s;
`else
            valid_s = 1'b1;
`endif
        end else begin
            valid_s = 1'b0;
        end
    end

    // Registered outputs, stable for the whole lifetime of a presented group.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            busy        <= 1'b0;
            grp_valid   <= 1'b0;
            grp_last    <= 1'b0;
            lane_en     <= '0;
            lane_offset <= '0;
            lane_addr   <= '0;
            done        <= 1'b0;
        end else begin
            busy        <= busy_s;
            grp_valid   <= valid_s;
            grp_last    <= last_s;
            lane_en     <= en_s;
            lane_offset <= off_s;
            lane_addr   <= addr_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_rv32v_lane_group_sequencer.sv
// Self-checking bench: directed scenarios plus random instructions against an element-level reference model.
module tb_rv32v_lane_group_sequencer;

    localparam int N      = 4;
    localparam int MAX_VL = 32;
    localparam int VL_W   = 6;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [N-1:0]      en;
        logic [N*VL_W-1:0] off;
        logic [N*XLEN-1:0] addr;
        logic              last;
    } beat_t;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              start = 1'b0;
    logic [VL_W-1:0]   vl = '0;
    logic              vm = 1'b0;
    logic [MAX_VL-1:0] mask_v0 = '0;
    logic [XLEN-1:0]   base_addr = '0;
    logic              stride_en = 1'b0;
    logic [XLEN-1:0]   stride = '0;
    logic [2:0]        eew_bytes = 3'd0;
    logic              flush = 1'b0;
    logic              grp_ready = 1'b0;
    logic              busy, grp_valid, grp_last, done;
    logic [N-1:0]      lane_en;
    logic [N*VL_W-1:0] lane_offset;
    logic [N*XLEN-1:0] lane_addr;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];
    logic [N*XLEN-1:0] seen_addr;

    rv32v_lane_group_sequencer #(.NUM_LANES(N), .MAX_VL(MAX_VL), .VL_W(VL_W), .XLEN(XLEN)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vm(vm), .mask_v0(mask_v0),
        .base_addr(base_addr), .stride_en(stride_en), .stride(stride), .eew_bytes(eew_bytes),
        .flush(flush), .grp_ready(grp_ready), .busy(busy), .grp_valid(grp_valid),
        .grp_last(grp_last), .lane_en(lane_en), .lane_offset(lane_offset),
        .lane_addr(lane_addr), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Element e of the instruction lives at base + e*step; groups are N consecutive elements.
    task automatic build(input int v, input logic m, input logic [31:0] mk, input logic [31:0] b,
                         input logic se, input logic [31:0] st, input logic [2:0] ew);
        logic [31:0] step;
        beat_t bt;
        int ng;
        exp_q.delete();
        step = se ? st : {29'd0, ew};
        ng = (v + N - 1) / N;
        for (int g = 0; g < ng; g++) begin
            bt = '0;
            for (int i = 0; i < N; i++) begin
                int e;
                e = g * N + i;
                bt.off[i*VL_W +: VL_W] = VL_W'(e);
                if (e < v) bt.en[i] = m ? 1'b1 : mk[e];
                bt.addr[i*XLEN +: XLEN] = b + 32'(e) * step;
            end
            bt.last = (g == ng - 1);
`ifdef RV32V_SEQ_SKIP_EMPTY_EN
            if (bt.en == '0) continue;
`endif
            exp_q.push_back(bt);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {busy, grp_valid, grp_last, done, lane_en}, '0);
        chk({tag, "_off"}, lane_offset, '0);
        chk({tag, "_addr"}, lane_addr, '0);
    endtask

    // Called at a negedge; returns at the negedge after the instruction went back to idle.
    task automatic run_instr(input int v, input logic m, input logic [31:0] mk, input logic [31:0] b,
                             input logic se, input logic [31:0] st, input logic [2:0] ew,
                             input int stalls, input bit rnd);
        int budget;
        bit seen_done;
        int stalls_left;
        beat_t bt;
        build(v, m, mk, b, se, st, ew);
        start = 1'b1; vl = VL_W'(v); vm = m; mask_v0 = mk; base_addr = b;
        stride_en = se; stride = st; eew_bytes = ew; grp_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        if (v == 0) chk("zero_vl_done", done, 1'b1);
        else chk("first_valid", grp_valid,
                 (exp_q.size() > 0 && exp_q[0].off[VL_W-1:0] == '0) ? 1'b1 : 1'b0);
        seen_done = 1'b0;
        budget = 0;
        stalls_left = stalls;
        while (!seen_done && budget < 300) begin
            budget++;
            if (done) begin
                seen_done = 1'b1;
                chk("beats_left", exp_q.size(), 0);
                chk("done_busy", busy, 1'b1);
                chk("done_valid", grp_valid, 1'b0);
            end else begin
                chk("busy", busy, 1'b1);
                if (stalls_left > 0) begin
                    grp_ready = 1'b0;
                    stalls_left--;
                end else begin
                    grp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (grp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1'b1, 1'b0);
                    end else begin
                        bt = exp_q[0];
                        chk("lane_en", lane_en, bt.en);
                        chk("lane_offset", lane_offset, bt.off);
                        chk("lane_addr", lane_addr, bt.addr);
                        chk("grp_last", grp_last, bt.last);
                        seen_addr = lane_addr;
                        if (grp_ready) void'(exp_q.pop_front());
                    end
                end
                @(negedge CLK);
            end
        end
        if (!seen_done) chk("timeout", 1'b0, 1'b1);
        grp_ready = 1'b0;
        @(negedge CLK);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
    endtask

    initial begin
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk_quiet("reset");
        nRST = 1'b1;
        @(negedge CLK);
        chk_quiet("idle");

        run_instr(6, 1'b1, 32'h0, 32'h1000, 1'b0, 32'h0, 3'd4, 0, 1'b0);
        chk("t1_beat1_addr", seen_addr, {32'h101C, 32'h1018, 32'h1014, 32'h1010});
        run_instr(4, 1'b1, 32'h0, 32'h20, 1'b1, 32'hFFFF_FFF8, 3'd4, 0, 1'b0);
        chk("t2_neg_stride", seen_addr, {32'h08, 32'h10, 32'h18, 32'h20});
        run_instr(8, 1'b1, 32'h0, 32'h40, 1'b0, 32'h0, 3'd2, 3, 1'b0);
        run_instr(8, 1'b0, 32'h0000_00A5, 32'h100, 1'b0, 32'h0, 3'd1, 0, 1'b0);
        run_instr(8, 1'b0, 32'h0000_000F, 32'h100, 1'b0, 32'h0, 3'd1, 0, 1'b0);
        run_instr(0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 3'd4, 0, 1'b0);
        run_instr(5, 1'b1, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0, 3'd4, 0, 1'b0);

        // Flush while the second group of a 12-element instruction is presented.
        start = 1'b1; vl = VL_W'(12); vm = 1'b1; base_addr = 32'h2000; stride_en = 1'b0;
        eew_bytes = 3'd4; grp_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        chk("fl_beat1_valid", grp_valid, 1'b1);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        grp_ready = 1'b0;
        chk_quiet("flush");
        run_instr(12, 1'b1, 32'h0, 32'h3000, 1'b0, 32'h0, 3'd2, 0, 1'b1);

        // Reset asserted mid-instruction.
        start = 1'b1; vl = VL_W'(12); vm = 1'b1; base_addr = 32'h4000; grp_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        chk_quiet("mid_reset");
        run_instr(9, 1'b0, 32'h0000_0155, 32'h5000, 1'b1, 32'h10, 3'd4, 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int rv;
            logic [2:0] ew;
            rv = int'($urandom_range(0, MAX_VL));
            ew = 3'(1 << $urandom_range(0, 2));
            run_instr(rv, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                      $urandom, ew, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
